// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite initiator: one single-beat command in flight, one response per command, >=3 cycles accept-to-rsp.
// Backpressure: cmd_ready stays low from command accept until the response handshake; rsp held until rsp_ready.
module axi_lite_master_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_fin;
  logic   w_fin;

  // A channel counts as finished if it already completed or completes this cycle.
  assign aw_fin = aw_done | (awvalid & awready);
  assign w_fin  = w_done  | (wvalid & wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      busy      <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              wstrb   <= cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR_REQ;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid && bready) begin
            bready    <= 1'b0;
            rsp_resp  <= bresp;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RD_REQ: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid && rready) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            rsp_write <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
